// File: rtl/nsum_inv_if.sv
// Request/result bundle for the triangular-root decoder.
// The master issues sums and the slave returns N, rem and ovf.
interface nsum_inv_if #(
    parameter int N_W   = 3,
    parameter int SUM_W = 5
);
    logic [SUM_W-1:0] S;
    logic             S_valid;
    logic             busy;
    logic [N_W-1:0]   N;
    logic [SUM_W-1:0] rem;
    logic             ovf;
    logic             N_valid;

    modport master (
        output S, S_valid,
        input  busy, N, rem, ovf, N_valid
    );

    modport slave (
        input  S, S_valid,
        output busy, N, rem, ovf, N_valid
    );
endinterface

// File: rtl/nsum_inv.sv
// Iterative inverse of NSum: subtracts 1, 2, 3, ... from S, one step per cycle,
// to find the largest N with N(N+1)/2 <= S and the leftover remainder.
module nsum_inv #(
    parameter int N_W   = 3,
    parameter int SUM_W = 5
) (
    input  logic     clk,
    input  logic     reset,
    nsum_inv_if.slave io
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [N_W-1:0] NMAX = '1;

    state_t           state_q, state_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [N_W:0]     k_q, k_d;
    logic [N_W-1:0]   n_q, n_d;
    logic             busy_q, busy_d;
    logic [N_W-1:0]   nres_q, nres_d;
    logic [SUM_W-1:0] rem_q, rem_d;
    logic             ovf_q, ovf_d;
    logic             nvld_q, nvld_d;
    logic [SUM_W-1:0] k_ext;

    assign k_ext = SUM_W'(k_q);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        k_d     = k_q;
        n_d     = n_q;
        busy_d  = busy_q;
        nres_d  = nres_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        nvld_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (io.S_valid) begin
                    acc_d   = io.S;
                    k_d     = (N_W+1)'(1);
                    n_d     = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (acc_q < k_ext) begin
                    nres_d  = n_q;
                    rem_d   = acc_q;
                    ovf_d   = 1'b0;
                    nvld_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (n_q == NMAX) begin
                    // Root does not fit in N_W bits; report unreduced acc.
                    nres_d  = n_q;
                    rem_d   = acc_q;
                    ovf_d   = 1'b1;
                    nvld_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    acc_d = acc_q - k_ext;
                    n_d   = n_q + N_W'(1);
                    k_d   = k_q + (N_W+1)'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            k_q     <= '0;
            n_q     <= '0;
            busy_q  <= 1'b0;
            nres_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            nvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            n_q     <= n_d;
            busy_q  <= busy_d;
            nres_q  <= nres_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            nvld_q  <= nvld_d;
        end
    end

    assign io.busy    = busy_q;
    assign io.N       = nres_q;
    assign io.rem     = rem_q;
    assign io.ovf     = ovf_q;
    assign io.N_valid = nvld_q;
endmodule

// File: tb/tb_nsum_inv.sv
// Scoreboard bench for nsum_inv: a default instance and a narrow-N instance
// that can reach overflow, both checked against a triangular-root model.
module tb_nsum_inv;
    logic clk;
    logic reset;

    nsum_inv_if #(.N_W(3), .SUM_W(5)) if1 ();
    nsum_inv_if #(.N_W(2), .SUM_W(5)) if2 ();

    nsum_inv #(.N_W(3), .SUM_W(5)) u_dut (
        .clk(clk), .reset(reset), .io(if1.slave)
    );
    nsum_inv #(.N_W(2), .SUM_W(5)) u_dut2 (
        .clk(clk), .reset(reset), .io(if2.slave)
    );

    typedef struct {
        int n;
        int r;
        int o;
        int cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int held_n[2];
    int held_r[2];
    int held_o[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Largest n (capped at nmax) with n(n+1)/2 <= s; overflow when the
    // remainder could still absorb the next step.
    function automatic void model(input int s, input int nmax,
                                  output int n, output int r, output int o);
        n = 0;
        while (n < nmax && (n + 1) * (n + 2) / 2 <= s) n++;
        r = s - n * (n + 1) / 2;
        o = (r >= n + 1) ? 1 : 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic bz(input int d);
        return (d == 0) ? if1.busy : if2.busy;
    endfunction

    task automatic mon(input int d);
        logic nv;
        int n, r, o, b;
        exp_t e;
        int qs;
        nv = (d == 0) ? if1.N_valid : if2.N_valid;
        n  = (d == 0) ? int'(if1.N) : int'(if2.N);
        r  = (d == 0) ? int'(if1.rem) : int'(if2.rem);
        o  = (d == 0) ? int'(if1.ovf) : int'(if2.ovf);
        b  = (d == 0) ? int'(if1.busy) : int'(if2.busy);
        qs = (d == 0) ? q1.size() : q2.size();
        if (nv) begin
            if (qs == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_nvalid dut%0d: got 1 want 0", d);
            end else begin
                e = (d == 0) ? q1.pop_front() : q2.pop_front();
                chk($sformatf("N dut%0d", d), n, e.n);
                chk($sformatf("rem dut%0d", d), r, e.r);
                chk($sformatf("ovf dut%0d", d), o, e.o);
                chk($sformatf("latency_cyc dut%0d", d), cyc, e.cyc);
                chk($sformatf("busy_at_result dut%0d", d), b, 0);
                held_n[d] = e.n;
                held_r[d] = e.r;
                held_o[d] = e.o;
            end
        end else begin
            chk($sformatf("held_N dut%0d", d), n, held_n[d]);
            chk($sformatf("held_rem dut%0d", d), r, held_r[d]);
            chk($sformatf("held_ovf dut%0d", d), o, held_o[d]);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            mon(0);
            mon(1);
        end
    end

    task automatic pulse(input int d, input int s);
        int n, r, o;
        exp_t e;
        if (d == 0) begin
            if1.S = 5'(s);
            if1.S_valid = 1'b1;
            if (!if1.busy) begin
                model(s, 7, n, r, o);
                e = '{n, r, o, cyc + n + 2};
                q1.push_back(e);
            end
        end else begin
            if2.S = 5'(s);
            if2.S_valid = 1'b1;
            if (!if2.busy) begin
                model(s, 3, n, r, o);
                e = '{n, r, o, cyc + n + 2};
                q2.push_back(e);
            end
        end
        @(negedge clk);
        if1.S_valid = 1'b0;
        if2.S_valid = 1'b0;
    endtask

    task automatic send(input int d, input int s);
        int t;
        t = 0;
        while (bz(d) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            total++;
            bad++;
            $display("FAIL busy_timeout dut%0d: got busy=1 want 0", d);
        end
        pulse(d, s);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy1"}, int'(if1.busy), 0);
        chk({tag, " N1"}, int'(if1.N), 0);
        chk({tag, " rem1"}, int'(if1.rem), 0);
        chk({tag, " ovf1"}, int'(if1.ovf), 0);
        chk({tag, " nvalid1"}, int'(if1.N_valid), 0);
        chk({tag, " busy2"}, int'(if2.busy), 0);
        chk({tag, " N2"}, int'(if2.N), 0);
        chk({tag, " rem2"}, int'(if2.rem), 0);
        chk({tag, " ovf2"}, int'(if2.ovf), 0);
        chk({tag, " nvalid2"}, int'(if2.N_valid), 0);
    endtask

    initial begin
        int t;
        if1.S = '0;
        if1.S_valid = 1'b0;
        if2.S = '0;
        if2.S_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            held_n[i] = 0;
            held_r[i] = 0;
            held_o[i] = 0;
        end
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        send(0, 15);
        send(0, 31);
        send(0, 0);
        send(0, 10);
        @(negedge clk);
        pulse(0, 4);
        send(0, 11);

        send(1, 20);
        send(1, 7);

        send(0, 28);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_zero("async_reset");
        q1.delete();
        q2.delete();
        for (int i = 0; i < 2; i++) begin
            held_n[i] = 0;
            held_r[i] = 0;
            held_o[i] = 0;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        send(0, 28);

        for (int s = 0; s < 32; s++) send(0, s);
        for (int s = 0; s < 32; s++) send(1, s);

        repeat (80) begin
            int d, s;
            d = int'($urandom_range(0, 1));
            s = int'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) pulse(d, s);
            else send(d, s);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        t = 0;
        while ((q1.size() != 0 || q2.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        if (q1.size() != 0 || q2.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0",
                     q1.size() + q2.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nsum_inv.md
Name: nsum_inv

Overview:
- Inverse of the NSum accumulator: given a sum S, finds the largest N with N(N+1)/2 <= S and reports the remainder S - N(N+1)/2.
- Works iteratively, subtracting 1, 2, 3, ... from S, one subtraction per cycle.
- Used to decode and check NSum results and to recover N from a transmitted sum, on the same pulse-valid style interface as NSum.

Parameters:
- N_W, 3, width of the recovered N.
- SUM_W, 5, width of the input sum and of the remainder.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- S  input  SUM_W  sum to decode; sampled only when S_valid=1 and busy=0.
- S_valid  input  1  one-cycle request strobe.
- busy  output  1  high while a decode is in progress; requests are ignored while high.
- N  output  N_W  recovered N; held until the next result.
- rem  output  SUM_W  remainder S - N(N+1)/2; held until the next result.
- ovf  output  1  root exceeded 2^N_W-1; held with N and rem.
- N_valid  output  1  one-cycle pulse marking a new N, rem and ovf.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, N=0, rem=0, ovf=0, N_valid=0; internal acc, k and n cleared.
- Reset mid-decode: the decode is aborted and no N_valid is produced.
- States: IDLE and RUN.
- IDLE:
  - On a rising edge with S_valid=1: acc<=S, k<=1, n<=0, state<=RUN, busy<=1.
  - S_valid=0: remain in IDLE.
- RUN, one decision per edge:
  - acc>=k and n<2^N_W-1: acc<=acc-k, n<=n+1, k<=k+1.
  - acc<k: N<=n, rem<=acc, ovf<=0, N_valid<=1, busy<=0, state<=IDLE.
  - acc>=k and n==2^N_W-1: N<=n, rem<=acc (not reduced), ovf<=1, N_valid<=1, busy<=0, state<=IDLE.
- Latency: for root n, N_valid rises n+1 edges after the accepting edge and stays high exactly one cycle.
  - S=0 gives a result 1 edge after accept.
- Widths:
  - k is N_W+1 bits.
  - The acc>=k compare is unsigned, with k zero-extended to SUM_W.
  - acc never underflows, because subtraction happens only when acc>=k.
- N_valid is 0 in every cycle except the result cycle.
- N, rem and ovf change only at a result edge.
- S_valid while busy=1: ignored, no effect on the running decode, not queued.
- Back-to-back requests:
  - busy=0 in the N_valid cycle, so an S_valid present in that cycle is accepted at the next edge.
  - That decode then proceeds normally.
- Simultaneous S_valid and reset=0: reset wins.

Test Plan:
- S=15 pulsed one cycle -> busy=1 for 6 cycles; N_valid one cycle 6 edges after accept; N=5, rem=0, ovf=0.
- S=31 -> N=7, rem=3, ovf=0 after 8 edges. Then S=0 -> N=0, rem=0 after 1 edge; N_valid never wider than one cycle.
- S=10 accepted; S=4 pulsed while busy -> that request is ignored; single result N=4, rem=0. Then S=11 pulsed in the N_valid cycle -> accepted; N=4, rem=1.
- N_W=2, SUM_W=5, S=20 -> ovf=1, N=3, rem=14 after 4 edges. Then S=7 -> ovf=0, N=3, rem=1.
- Reset driven low mid-decode of S=28 -> outputs go to zero immediately and no N_valid follows. After release, S=28 -> N=7, rem=0.
- Exhaustive check, S=0..31 with default parameters -> each result matches the reference triangular root and remainder, and latency equals N+1 edges.
